// File: rtl/mem_request_arbiter_pkg.sv
// mem_request_arbiter_pkg: shared types for the memory request arbiter
package mem_request_arbiter_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} arb_state_t;
  typedef enum logic {INSTR, DATA} grant_t;
endpackage

// File: rtl/mem_request_arbiter_if.sv
// mem_request_arbiter_if: datapath request/response and RAM signals around the arbiter
interface mem_request_arbiter_if;
  import mem_request_arbiter_pkg::*;
  logic iREN, dREN, dWEN, halt, ihit, dhit, ramREN, ramWEN, mem_err;
  word_t iaddr, daddr, dstore, iload, dload, ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  modport slave (
    input iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramstate, ramload,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramstate, ramload,
    input ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );
endinterface

// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter: serialises fetch/data requests onto a single-port RAM; MEM_TIMEOUT_EN adds an access timeout
module mem_request_arbiter
  import mem_request_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit FAIR_EN_DEFAULT = 1'b1
) (
  input logic CLK,
  input logic RST,
  mem_request_arbiter_if.slave bus
);
  arb_state_t state_q, state_d;
  grant_t last_grant_q, last_grant_d;
  word_t addr_q, addr_d, store_q, store_d, iload_q, iload_d, dload_q, dload_d;
  logic wr_q, wr_d, mem_err_q, mem_err_d, in_acc, i_req, d_req, timeout;
  assign in_acc = (state_q == DACC) || (state_q == IACC);
  assign i_req = bus.iREN && !bus.halt;
  assign d_req = (bus.dREN || bus.dWEN) && !(FAIR_EN_DEFAULT && i_req && last_grant_q == DATA);
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 8-bit wait counter");
  end
`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  assign timeout = cnt_q == 8'(TIMEOUT_CYCLES - 1);
  // Held at zero outside the access states, so it starts from zero on every entry
  always_comb cnt_d = !in_acc ? 8'd0 : (cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1);
  always_ff @(posedge CLK) cnt_q <= RST ? 8'd0 : cnt_d;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    last_grant_d = last_grant_q;
    addr_d = addr_q;
    store_d = store_q;
    wr_d = wr_q;
    iload_d = iload_q;
    dload_d = dload_q;
    mem_err_d = mem_err_q;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d = DACC;
          addr_d = bus.daddr;
          store_d = bus.dstore;
          wr_d = bus.dWEN;
        end else if (i_req) begin
          state_d = IACC;
          addr_d = bus.iaddr;
          wr_d = 1'b0;
        end
      end
      DACC, IACC: begin
        if (bus.ramstate == ACCESS) begin
          state_d = RESP;
          last_grant_d = (state_q == DACC) ? DATA : INSTR;
          iload_d = (state_q == IACC) ? bus.ramload : iload_q;
          dload_d = (state_q == DACC && !wr_q) ? bus.ramload : dload_q;
        end else if (bus.ramstate == ERROR || timeout) begin
          state_d = IDLE;
          mem_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      last_grant_q <= INSTR;
      addr_q <= '0;
      store_q <= '0;
      wr_q <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      addr_q <= addr_d;
      store_q <= store_d;
      wr_q <= wr_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      mem_err_q <= mem_err_d;
    end
  end
  assign bus.ihit = state_q == RESP && last_grant_q == INSTR;
  assign bus.dhit = state_q == RESP && last_grant_q == DATA;
  assign bus.iload = iload_q;
  assign bus.dload = dload_q;
  assign bus.ramREN = (state_q == IACC) || (state_q == DACC && !wr_q);
  assign bus.ramWEN = state_q == DACC && wr_q;
  assign bus.ramaddr = addr_q;
  assign bus.ramstore = store_q;
  assign bus.mem_err = mem_err_q;
endmodule
